// File: rtl/space_wire_time_code_scheduler.sv
// ---------------------------------------------------------------------------
// space_wire_time_code_scheduler
//
// Time-master sequencer for the SpaceWire time-code transmit path. It merges
// host tick requests and an optional periodic auto-tick into single time-code
// issues. It keeps the local 6-bit time counter, forms {flags, time}, and
// hands the code to the link transmitter over a req/ack handshake.
//
// Ports
//   i_clk, i_reset_n            clock, async active-low reset
//   i_enable                    block enable (0 forces IDLE, stops timer)
//   i_link_running              transmitter link in Run state
//   i_auto_mode, i_period       periodic auto-tick control (period 0 = off)
//   i_tick_in                   host tick request pulse
//   i_control_flags_in          flags placed in code bits [7:6]
//   i_time_load, i_time_in      load the time counter
//   o_tx_tick_req/o_tx_time_code/i_tx_tick_ack   transmitter handshake
//   o_time_out                  current time counter
//   o_busy                      high while a code is outstanding
//   o_tick_dropped              1-cycle pulse on discarded tick / aborted issue
// ---------------------------------------------------------------------------
module space_wire_time_code_scheduler #(
  parameter int PERIOD_WIDTH = 16,
  parameter int ACK_TIMEOUT  = 1023
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic                    i_link_running,
  input  logic                    i_auto_mode,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic                    i_tick_in,
  input  logic [1:0]              i_control_flags_in,
  input  logic                    i_time_load,
  input  logic [5:0]              i_time_in,
  output logic                    o_tx_tick_req,
  output logic [7:0]              o_tx_time_code,
  input  logic                    i_tx_tick_ack,
  output logic [5:0]              o_time_out,
  output logic                    o_busy,
  output logic                    o_tick_dropped
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  // Value of the wait counter in the last REQ cycle before a timeout abort;
  // the request is therefore held for ACK_TIMEOUT cycles at most.
  localparam logic [TW-1:0] LP_WAIT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                  r_state;
  logic [PERIOD_WIDTH-1:0] r_timer;
  logic [TW-1:0]           r_wait;
  logic [5:0]              r_time;
  logic [7:0]              r_code;
  logic                    r_req;
  logic                    r_busy;
  logic                    r_drop;

  logic                    w_count_en;
  logic                    w_auto_fire;
  logic                    w_event;
  logic [5:0]              w_time_inc;

  assign w_count_en  = i_enable && i_auto_mode && (i_period != '0);
  // Equality compare only: if the period shrinks below the current timer,
  // the timer runs through its natural wrap before matching again.
  assign w_auto_fire = w_count_en && (r_timer == (i_period - PERIOD_WIDTH'(1)));
  assign w_event     = i_tick_in || w_auto_fire;
  // A load in the same cycle as an issue takes effect before the increment.
  assign w_time_inc  = (i_time_load ? i_time_in : r_time) + 6'd1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_wait  <= '0;
      r_time  <= '0;
      r_code  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (!w_count_en || w_auto_fire) r_timer <= '0;
      else                            r_timer <= r_timer + PERIOD_WIDTH'(1);

      r_drop <= 1'b0;
      if (i_time_load) r_time <= i_time_in;

      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            if (i_enable && i_link_running) begin
              r_state <= S_REQ;
              r_time  <= w_time_inc;
              r_code  <= {i_control_flags_in, w_time_inc};
              r_req   <= 1'b1;
              r_busy  <= 1'b1;
              r_wait  <= '0;
            end else begin
              r_drop  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Codes are never queued: any event while outstanding is lost.
          if (w_event) r_drop <= 1'b1;
          if (i_tx_tick_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!i_enable || !i_link_running || r_wait == LP_WAIT_LAST) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b1;
          end else begin
            r_wait  <= r_wait + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_tick_req  = r_req;
  assign o_tx_time_code = r_code;
  assign o_time_out     = r_time;
  assign o_busy         = r_busy;
  assign o_tick_dropped = r_drop;

endmodule

// File: tb/tb_space_wire_time_code_scheduler.sv
module tb_space_wire_time_code_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable, i_link_running, i_auto_mode, i_tick_in, i_time_load, i_tx_tick_ack;
  logic [15:0] i_period;
  logic [1:0]  i_flags;
  logic [5:0]  i_time_in;
  logic        o_req, o_busy, o_drop;
  logic [7:0]  o_code;
  logic [5:0]  o_time;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  space_wire_time_code_scheduler #(.PERIOD_WIDTH(16), .ACK_TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(i_enable), .i_link_running(i_link_running),
    .i_auto_mode(i_auto_mode), .i_period(i_period), .i_tick_in(i_tick_in),
    .i_control_flags_in(i_flags), .i_time_load(i_time_load), .i_time_in(i_time_in),
    .o_tx_tick_req(o_req), .o_tx_time_code(o_code), .i_tx_tick_ack(i_tx_tick_ack),
    .o_time_out(o_time), .o_busy(o_busy), .o_tick_dropped(o_drop)
  );

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_enable = 1'b1; i_link_running = 1'b1; i_auto_mode = 1'b0;
    i_period = 16'd0; i_tick_in = 1'b0; i_flags = 2'b00; i_time_load = 1'b0;
    i_time_in = 6'd0; i_tx_tick_ack = 1'b0;
    cyc(); cyc();
    checks++;
    if ({o_req, o_busy, o_drop, o_code, o_time} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b busy=%b drop=%b code=%h time=%0d, need all zero",
               o_req, o_busy, o_drop, o_code, o_time);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    i_flags = 2'b01; i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    checks++;
    if (o_req !== 1'b1 || o_busy !== 1'b1 || o_code !== 8'h41 || o_time !== 6'd1 || o_drop !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue: got req=%b busy=%b code=%h time=%0d drop=%b, need 1 1 41 1 0",
               o_req, o_busy, o_code, o_time, o_drop);
    end
    cyc(); cyc();
    checks++;
    if (o_req !== 1'b1) begin errors++; $display("FAIL basic_hold: got req=%b, need 1", o_req); end
    i_tx_tick_ack = 1'b1; cyc(); i_tx_tick_ack = 1'b0;
    checks++;
    if (o_req !== 1'b0 || o_busy !== 1'b0 || o_code !== 8'h41 || o_drop !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got req=%b busy=%b code=%h drop=%b, need 0 0 41 0", o_req, o_busy, o_code, o_drop);
    end
  endtask

  task automatic test_wrap();
    i_flags = 2'b00; i_time_load = 1'b1; i_time_in = 6'd63; cyc(); i_time_load = 1'b0;
    checks++;
    if (o_time !== 6'd63 || o_req !== 1'b0) begin
      errors++; $display("FAIL wrap_load: got time=%0d req=%b, need 63 0", o_time, o_req);
    end
    i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    checks++;
    if (o_code !== 8'h00 || o_time !== 6'd0 || o_req !== 1'b1) begin
      errors++; $display("FAIL wrap_issue: got code=%h time=%0d req=%b, need 00 0 1", o_code, o_time, o_req);
    end
    i_tx_tick_ack = 1'b1; cyc(); i_tx_tick_ack = 1'b0;
    checks++;
    if (o_req !== 1'b0) begin errors++; $display("FAIL wrap_ack: got req=%b, need 0", o_req); end
  endtask

  task automatic test_auto();
    int rises, drops, ack_at;
    int rise_at[3];
    logic [7:0] rise_code[3];
    logic prev;
    rises = 0; drops = 0; ack_at = -1; prev = 1'b0;
    i_period = 16'd10; i_auto_mode = 1'b1;
    for (int c = 0; c < 35; c++) begin
      i_tx_tick_ack = (c == ack_at);
      cyc();
      if (o_drop) drops++;
      if (o_req && !prev) begin
        if (rises < 3) begin rise_at[rises] = c; rise_code[rises] = o_code; end
        rises++;
        ack_at = c + 2;
      end
      prev = o_req;
    end
    i_tx_tick_ack = 1'b0; i_auto_mode = 1'b0;
    checks++;
    if (rises !== 3 || drops !== 0) begin
      errors++; $display("FAIL auto_count: got rises=%0d drops=%0d, need 3 0", rises, drops);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rise_at[k] !== 9 + 10 * k || rise_code[k] !== 8'(k + 1)) begin
          errors++;
          $display("FAIL auto_rise%0d: got cycle=%0d code=%h, need cycle=%0d code=%h",
                   k, rise_at[k], rise_code[k], 9 + 10 * k, 8'(k + 1));
        end
      end
    end
  endtask

  task automatic test_drop_in_req();
    i_tick_in = 1'b1; cyc();
    checks++;
    if (o_req !== 1'b1 || o_time !== 6'd4 || o_code !== 8'h04) begin
      errors++; $display("FAIL drop_issue: got req=%b time=%0d code=%h, need 1 4 04", o_req, o_time, o_code);
    end
    cyc(); i_tick_in = 1'b0;
    checks++;
    if (o_drop !== 1'b1 || o_req !== 1'b1 || o_time !== 6'd4) begin
      errors++; $display("FAIL drop_busy_tick: got drop=%b req=%b time=%0d, need 1 1 4", o_drop, o_req, o_time);
    end
    cyc();
    checks++;
    if (o_drop !== 1'b0) begin errors++; $display("FAIL drop_single_pulse: got drop=%b, need 0", o_drop); end
    i_tick_in = 1'b1; i_tx_tick_ack = 1'b1; cyc(); i_tick_in = 1'b0; i_tx_tick_ack = 1'b0;
    checks++;
    if (o_drop !== 1'b1 || o_req !== 1'b0 || o_time !== 6'd4) begin
      errors++; $display("FAIL drop_at_ack: got drop=%b req=%b time=%0d, need 1 0 4", o_drop, o_req, o_time);
    end
    cyc();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (o_req !== 1'b1 || o_drop !== 1'b0) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad wait cycles, need 0", early); end
    cyc();
    checks++;
    if (o_req !== 1'b0 || o_drop !== 1'b1 || o_time !== 6'd5) begin
      errors++; $display("FAIL timeout_abort: got req=%b drop=%b time=%0d, need 0 1 5", o_req, o_drop, o_time);
    end
    cyc();
  endtask

  task automatic test_link_drop();
    i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    cyc();
    i_link_running = 1'b0; cyc();
    checks++;
    if (o_req !== 1'b0 || o_busy !== 1'b0 || o_drop !== 1'b1 || o_time !== 6'd6) begin
      errors++; $display("FAIL link_abort: got req=%b busy=%b drop=%b time=%0d, need 0 0 1 6", o_req, o_busy, o_drop, o_time);
    end
    i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    checks++;
    if (o_req !== 1'b0 || o_drop !== 1'b1 || o_time !== 6'd6) begin
      errors++; $display("FAIL link_down_tick: got req=%b drop=%b time=%0d, need 0 1 6", o_req, o_drop, o_time);
    end
    i_link_running = 1'b1; i_enable = 1'b0; i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    checks++;
    if (o_req !== 1'b0 || o_drop !== 1'b1 || o_time !== 6'd6) begin
      errors++; $display("FAIL disabled_tick: got req=%b drop=%b time=%0d, need 0 1 6", o_req, o_drop, o_time);
    end
    i_enable = 1'b1; cyc();
  endtask

  task automatic test_load();
    i_flags = 2'b10; i_time_load = 1'b1; i_time_in = 6'd20; i_tick_in = 1'b1; cyc();
    i_time_load = 1'b0; i_tick_in = 1'b0;
    checks++;
    if (o_req !== 1'b1 || o_code !== 8'h95 || o_time !== 6'd21) begin
      errors++; $display("FAIL load_issue: got req=%b code=%h time=%0d, need 1 95 21", o_req, o_code, o_time);
    end
    i_tx_tick_ack = 1'b1; cyc(); i_tx_tick_ack = 1'b0;
    i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    i_time_load = 1'b1; i_time_in = 6'd40; cyc(); i_time_load = 1'b0;
    checks++;
    if (o_req !== 1'b1 || o_code !== 8'h96 || o_time !== 6'd40) begin
      errors++; $display("FAIL load_in_req: got req=%b code=%h time=%0d, need 1 96 40", o_req, o_code, o_time);
    end
    i_tx_tick_ack = 1'b1; cyc(); i_tx_tick_ack = 1'b0;
    i_tx_tick_ack = 1'b1; cyc(); i_tx_tick_ack = 1'b0;
    checks++;
    if (o_req !== 1'b0 || o_drop !== 1'b0 || o_time !== 6'd40) begin
      errors++; $display("FAIL ack_in_idle: got req=%b drop=%b time=%0d, need 0 0 40", o_req, o_drop, o_time);
    end
  endtask

  task automatic test_reset_mid_req();
    i_tick_in = 1'b1; cyc(); i_tick_in = 1'b0;
    checks++;
    if (o_req !== 1'b1 || o_code !== 8'hA9) begin
      errors++; $display("FAIL rst_pre_issue: got req=%b code=%h, need 1 a9", o_req, o_code);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_req !== 1'b0 || o_busy !== 1'b0 || o_code !== 8'h00 || o_time !== 6'd0) begin
      errors++; $display("FAIL rst_async: got req=%b busy=%b code=%h time=%0d, need 0 0 00 0", o_req, o_busy, o_code, o_time);
    end
    cyc(); rst_n = 1'b1; cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_auto();
    test_drop_in_req();
    test_timeout();
    test_link_drop();
    test_load();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/space_wire_time_code_scheduler.md
Name: space_wire_time_code_scheduler

Overview:
Time-master sequencer for the SpaceWire time-code transmit path. It merges host tick requests and an optional periodic auto-tick into single time-code issues. It maintains the local 6-bit time counter and forms the 8-bit time-code, then hands the code to the link transmitter with a req/ack handshake. It sits beside the receive-side time-code control logic, on the i_clk (system) domain.

Parameters:
PERIOD_WIDTH, 16, width of auto-tick period register in i_clk cycles
ACK_TIMEOUT, 1023, max cycles o_tx_tick_req may wait for i_tx_tick_ack before abort (>=1)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset_n  input  1  reset; asynchronous, active-low
i_enable  input  1  block enable; 0 forces IDLE, stops timer
i_link_running  input  1  transmitter link in Run state
i_auto_mode  input  1  1 = periodic auto-tick active
i_period  input  PERIOD_WIDTH  auto-tick period in cycles; 0 = auto disabled
i_tick_in  input  1  host tick request, 1-cycle pulse
i_control_flags_in  input  2  control flags placed in code bits [7:6]
i_time_load  input  1  load time counter from i_time_in (1-cycle pulse)
i_time_in  input  6  value for i_time_load
o_tx_tick_req  output  1  time-code request to transmitter, held until ack
o_tx_time_code  output  8  {flags, time}; stable while o_tx_tick_req=1
i_tx_tick_ack  input  1  transmitter accepted code (1 cycle)
o_time_out  output  6  current time counter
o_busy  output  1  high in REQ state
o_tick_dropped  output  1  1-cycle pulse: tick request discarded or issue aborted

Behaviour:
- Reset (i_reset_n=0, async): state IDLE; time counter=0; period timer=0; o_tx_tick_req=0; o_tx_time_code=8'h00; o_time_out=0; o_busy=0; o_tick_dropped=0.
- Tick source event E = i_tick_in OR auto_fire. Simultaneous host+auto in one cycle = one event, no drop.
- Period timer: counts only when i_enable && i_auto_mode && i_period!=0. When timer==i_period-1, auto_fire=1 for that cycle and timer goes to 0. Timer clears to 0 whenever the count condition is false. It keeps counting in REQ state. i_period changes take effect on the next compare. If timer >= new period, it runs to wrap, 2^PERIOD_WIDTH modulo.
- States: IDLE, REQ.
- IDLE, E && i_enable && i_link_running at cycle N:
  - at N+1: time counter = old+1 (mod 64, 63->0).
  - o_tx_time_code = {i_control_flags_in sampled at N, old+1}.
  - o_tx_tick_req=1, o_busy=1, state REQ, timeout counter=0.
- IDLE, E && (!i_link_running || !i_enable): no issue, counter unchanged, o_tick_dropped=1 at N+1.
- REQ, i_tx_tick_ack at cycle M: o_tx_tick_req=0, o_busy=0, state IDLE at M+1. New events are accepted from M+1 on.
- REQ, any E (including at ack cycle M): discarded, o_tick_dropped=1 next cycle. Time-codes are never queued.
- REQ, !i_link_running or !i_enable: abort to IDLE next cycle, req=0, o_tick_dropped=1. Counter keeps incremented value.
- REQ, timeout counter reaches ACK_TIMEOUT with no ack: abort as above.
- Multiple drop causes in one cycle: single pulse.
- o_tx_time_code holds last issued value after ack/abort.
- i_time_load: counter=i_time_in next cycle, in any state. Does not alter a code already held in REQ. Load and issue in same IDLE cycle: load wins, issued code = {flags, i_time_in+1}.
- i_tx_tick_ack while IDLE: ignored.
- o_time_out = counter register, no extra latency.

Test Plan:
- Reset then i_tick_in pulse, flags=2'b01, link running -> next cycle req=1, code=8'h41, o_time_out=1. Ack 3 cycles later -> req=0 following cycle.
- Counter at 63, tick+ack -> code low bits=0, o_time_out=0 (wrap).
- i_auto_mode=1, i_period=10, ack 2 cycles after each req -> req rises every 10 cycles, codes 1,2,3…, no drops.
- Tick while REQ and tick coincident with ack -> both dropped (o_tick_dropped pulse each), counter unchanged.
- Never ack, ACK_TIMEOUT=8 -> req drops after 8 wait cycles, drop pulse. Link drop mid-REQ -> abort, drop pulse, counter retains new value.
- i_time_load=1, i_time_in=6'd20 with simultaneous tick in IDLE -> code time=21, o_time_out=21. Reset asserted mid-REQ -> req=0 immediately.
